// File: rtl/step_controller_if.sv
// Instruction handshake between the step controller (master) and the interpreter (slave).
interface step_controller_if;
  logic exec_req;
  logic exec_ack;
  logic exec_done;
  logic exec_pass;

  modport master (
    output exec_req,
    input  exec_ack,
    input  exec_done,
    input  exec_pass
  );

  modport slave (
    input  exec_req,
    output exec_ack,
    output exec_done,
    output exec_pass
  );
endinterface

// File: rtl/step_controller.sv
// Run/step sequencer for an instruction interpreter: counts steps, enforces a step limit, reports result.
// Optional single-step mode is enabled by defining STEP_CONTROLLER_SINGLE_EN.
module step_controller #(
  parameter int STEP_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  abort,
  input  logic [STEP_WIDTH-1:0] step_limit,
  input  logic                  single,
  input  logic                  advance,
  step_controller_if.master     ex,
  output logic [STEP_WIDTH-1:0] steps,
  output logic                  busy,
  output logic                  finished,
  output logic                  success,
  output logic                  timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, PAUSE, DONE} state_t;

  state_t                state;
  logic                  run_q;
  logic                  armed;
  logic                  start;
  logic                  accept;
  logic                  single_mode;
  logic                  advance_en;
  logic [STEP_WIDTH-1:0] steps_inc;

`ifdef STEP_CONTROLLER_SINGLE_EN
  assign single_mode = single;
  assign advance_en  = advance;
`else
  logic unused_single;
  assign unused_single = single ^ advance;
  assign single_mode   = 1'b0;
  assign advance_en    = 1'b0;
`endif

  // armed only rises once run has been seen low, so a run held high through reset never starts
  assign start     = run & ~run_q & armed;
  assign accept    = ex.exec_req & ex.exec_ack;
  assign steps_inc = steps + STEP_WIDTH'(1);

  // NOTE: state and outputs use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      run_q       <= 1'b0;
      armed       <= 1'b0;
      ex.exec_req <= 1'b0;
      steps       <= '0;
      busy        <= 1'b0;
      finished    <= 1'b0;
      success     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      run_q <= run;
      if (!run) armed <= 1'b1;
      if (accept) steps <= steps_inc;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            steps    <= '0;
            finished <= 1'b0;
            success  <= 1'b0;
            timeout  <= 1'b0;
            busy     <= 1'b1;
            if (single_mode) begin
              state       <= PAUSE;
              ex.exec_req <= 1'b0;
            end else begin
              state       <= ISSUE;
              ex.exec_req <= 1'b1;
            end
          end
        end

        ISSUE: begin
          if (abort) begin
            state       <= DONE;
            ex.exec_req <= 1'b0;
            busy        <= 1'b0;
            finished    <= 1'b1;
            success     <= 1'b0;
            timeout     <= 1'b0;
          end else if (accept) begin
            if (ex.exec_done) begin
              state       <= DONE;
              ex.exec_req <= 1'b0;
              busy        <= 1'b0;
              finished    <= 1'b1;
              success     <= ex.exec_pass;
              timeout     <= 1'b0;
            end else if ((step_limit != '0) && (steps_inc == step_limit)) begin
              state       <= DONE;
              ex.exec_req <= 1'b0;
              busy        <= 1'b0;
              finished    <= 1'b1;
              success     <= 1'b0;
              timeout     <= 1'b1;
            end else if (single_mode) begin
              state       <= PAUSE;
              ex.exec_req <= 1'b0;
            end
          end
        end

        PAUSE: begin
          if (abort) begin
            state       <= DONE;
            ex.exec_req <= 1'b0;
            busy        <= 1'b0;
            finished    <= 1'b1;
            success     <= 1'b0;
            timeout     <= 1'b0;
          end else if (advance_en) begin
            state       <= ISSUE;
            ex.exec_req <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_step_controller.sv
// Self-checking bench for step_controller: directed scenarios plus randomized traffic against a run-level model.
module tb_step_controller;
  localparam int W = 8;

`ifdef STEP_CONTROLLER_SINGLE_EN
  localparam bit SINGLE_EN = 1'b1;
`else
  localparam bit SINGLE_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         run = 1'b0;
  logic         abort = 1'b0;
  logic         single = 1'b0;
  logic         advance = 1'b0;
  logic [W-1:0] step_limit = '0;
  logic [W-1:0] steps;
  logic         busy, finished, success, timeout;

  step_controller_if ex_bus ();

  step_controller #(.STEP_WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
    .abort      (abort),
    .step_limit (step_limit),
    .single     (single),
    .advance    (advance),
    .ex         (ex_bus),
    .steps      (steps),
    .busy       (busy),
    .finished   (finished),
    .success    (success),
    .timeout    (timeout)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Run-level model: a run is active or not, waiting for a permit or not.
  bit m_active, m_waiting, m_fin, m_pass, m_limit_hit, m_prev_run, m_armed;
  int m_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_waiting = 0; m_fin = 0; m_pass = 0; m_limit_hit = 0;
    m_prev_run = 0; m_armed = 0; m_count = 0;
  endtask

  task automatic end_run(input bit pass, input bit limit_hit);
    m_active = 0; m_waiting = 0; m_fin = 1; m_pass = pass; m_limit_hit = limit_hit;
  endtask

  // Applies the rules for one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit st;
    st = run && !m_prev_run && m_armed;
    m_prev_run = run;
    if (!run) m_armed = 1;
    if (!m_active) begin
      if (st) begin
        m_count = 0; m_fin = 0; m_pass = 0; m_limit_hit = 0;
        m_active = 1;
        m_waiting = SINGLE_EN && single;
      end
    end else if (m_waiting) begin
      if (abort) end_run(0, 0);
      else if (SINGLE_EN && advance) m_waiting = 0;
    end else begin
      if (ex_bus.exec_ack) m_count = (m_count + 1) % (1 << W);
      if (abort) end_run(0, 0);
      else if (ex_bus.exec_ack) begin
        if (ex_bus.exec_done) end_run(ex_bus.exec_pass, 0);
        else if (step_limit != 0 && m_count == int'(step_limit)) end_run(0, 1);
        else m_waiting = SINGLE_EN && single;
      end
    end
  endtask

  task automatic compare_all();
    check("steps",    32'(steps),            32'(m_count));
    check("busy",     32'(busy),             32'(m_active));
    check("finished", 32'(finished),         32'(m_fin));
    check("success",  32'(success),          32'(m_pass));
    check("timeout",  32'(timeout),          32'(m_limit_hit));
    check("exec_req", 32'(ex_bus.exec_req),  32'(m_active && !m_waiting));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    @(negedge clock);
    compare_all();
  endtask

  task automatic set_ex(input bit a, input bit d, input bit p);
    ex_bus.exec_ack  = a;
    ex_bus.exec_done = d;
    ex_bus.exec_pass = p;
  endtask

  task automatic start_run(input bit sg, input logic [W-1:0] lim);
    step_limit = lim;
    single     = sg;
    set_ex(0, 0, 0);
    run = 1'b0;
    tick();
    run = 1'b1;
    tick();
  endtask

  initial begin
    set_ex(0, 0, 0);
    model_reset();
    #1;
    check("rst_steps", 32'(steps), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_req",   32'(ex_bus.exec_req), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    // Test 1: unlimited run, interpreter finishes with pass on the 6th ack
    start_run(0, 0);
    for (int i = 1; i <= 6; i++) begin
      set_ex(1, i == 6, 1);
      tick();
    end
    set_ex(0, 0, 0);
    tick();
    check("t1_steps",    32'(steps),    32'd6);
    check("t1_finished", 32'(finished), 32'd1);
    check("t1_success",  32'(success),  32'd1);
    check("t1_timeout",  32'(timeout),  32'd0);
    check("t1_req",      32'(ex_bus.exec_req), 32'd0);

    // Test 2: step limit of 4 hit without the interpreter finishing
    start_run(0, 4);
    for (int i = 0; i < 6; i++) begin
      set_ex(1, 0, 0);
      tick();
    end
    set_ex(0, 0, 0);
    check("t2_steps",   32'(steps),   32'd4);
    check("t2_timeout", 32'(timeout), 32'd1);
    check("t2_success", 32'(success), 32'd0);

    // Test 3: single-step, three permits
    start_run(1, 0);
    for (int i = 0; i < 3; i++) begin
      advance = 1'b1;
      tick();
      advance = 1'b0;
      set_ex(1, 0, 0);
      tick();
      set_ex(0, 0, 0);
    end
    tick();
`ifdef STEP_CONTROLLER_SINGLE_EN
    check("t3_steps",    32'(steps),    32'd3);
    check("t3_busy",     32'(busy),     32'd1);
    check("t3_finished", 32'(finished), 32'd0);
    check("t3_req",      32'(ex_bus.exec_req), 32'd0);
`endif
    abort = 1'b1;
    tick();
    abort = 1'b0;
    single = 1'b0;

    // Test 4: finishing on the same ack that reaches the limit counts as a pass
    start_run(0, 6);
    for (int i = 1; i <= 6; i++) begin
      set_ex(1, i == 6, 1);
      tick();
    end
    set_ex(0, 0, 0);
    check("t4_success", 32'(success), 32'd1);
    check("t4_timeout", 32'(timeout), 32'd0);

    // Test 5: asynchronous reset mid-run, then run held high through release
    start_run(0, 0);
    set_ex(1, 0, 0);
    tick();
    tick();
    set_ex(0, 0, 0);
    tick();
    #2 reset = 1'b0;
    #1;
    check("t5_steps",    32'(steps),    32'd0);
    check("t5_busy",     32'(busy),     32'd0);
    check("t5_finished", 32'(finished), 32'd0);
    check("t5_success",  32'(success),  32'd0);
    check("t5_timeout",  32'(timeout),  32'd0);
    check("t5_req",      32'(ex_bus.exec_req), 32'd0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("t5_no_start", 32'(busy), 32'd0);
    run = 1'b0;
    tick();
    run = 1'b1;
    tick();
    check("t5_restart", 32'(busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Test 6: restart ignored while busy, abort with coincident ack, fresh start clears
    start_run(0, 0);
    run = 1'b0;
    tick();
    run = 1'b1;
    tick();
    check("t6_ignored", 32'(steps), 32'd0);
    set_ex(1, 1, 1);
    tick();
    set_ex(0, 0, 0);
    start_run(0, 0);
    set_ex(1, 0, 0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    set_ex(0, 0, 0);
    check("t6_steps",    32'(steps),    32'd2);
    check("t6_finished", 32'(finished), 32'd1);
    check("t6_success",  32'(success),  32'd0);
    start_run(0, 0);
    check("t6_cleared",  32'(steps),    32'd0);

    // Counter wrap on an unlimited run
    set_ex(1, 0, 0);
    for (int i = 0; i < (1 << W) + 1; i++) tick();
    set_ex(0, 0, 0);
    check("wrap_steps", 32'(steps), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 8) run = ~run;
      abort   = ($urandom_range(99) < 3);
      advance = ($urandom_range(99) < 30);
      if ($urandom_range(99) < 3) single = ~single;
      if ($urandom_range(99) < 5) step_limit = W'($urandom_range(6));
      set_ex($urandom_range(99) < 60, $urandom_range(99) < 15, 1'($urandom_range(1)));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
